sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter that shares the single SRAM controller between the MEM-stage data port (port 0) and a secondary requester such as a DMA/loader (port 1). It sits between the requesters and the SRAM controller's golden-input/ready interface. It latches one request at a time, holds the controller enables for exactly one transaction, returns read data and a one-cycle acknowledge, and provides per-port freeze signals. Grants alternate round-robin.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `FIXED_PRIO`, 0, 1 = port 0 always wins ties; 0 = round-robin
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `p0_req`, `p1_req` in 1 each: request; held high until the matching ack
- `p0_we`, `p1_we` in 1 each: 1 = write, 0 = read
- `p0_addr`, `p1_addr` in ADDR_W each: byte address
- `p0_wdata`, `p1_wdata` in DATA_W each: write data
- `p0_rdata`, `p1_rdata` out DATA_W each: registered read data
- `p0_ack`, `p1_ack` out 1 each: one-cycle completion pulse
- `p0_ready`, `p1_ready` out 1 each: freeze, 0 = stall; equals `~(pN_req & ~pN_ack)`
- `mem_read_en`, `mem_write_en` out 1 each: to the SRAM controller
- `mem_address` out ADDR_W: to the SRAM controller
- `mem_write_data` out DATA_W: to the SRAM controller
- `mem_read_data` in DATA_W: from the SRAM controller
- `mem_ready` in 1: from the SRAM controller; low while a transaction is busy
- `gnt` out 1: index of the port owning the current or last transaction
- `busy` out 1: high in BUSY and RESP

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any request is pending, pick the winner:
    - Only one port requesting: that port wins.
    - Both requesting, `FIXED_PRIO` = 1: port 0 wins.
    - Both requesting, `FIXED_PRIO` = 0: the port not equal to `last_gnt` wins.
  - On a win: register `gnt`, `we`, `addr` and `wdata` into the command registers, then go to BUSY.
  - With no request, stay in IDLE.
- **BUSY**
  - Drive from the command registers: `mem_read_en = ~we`, `mem_write_en = we`, `mem_address`, `mem_write_data`.
  - Requester inputs are ignored; later changes do not affect the transaction.
  - When `mem_ready` = 1, the transaction is complete:
    - For a read, capture `mem_read_data` into `p<gnt>_rdata`.
    - Go to RESP.
- **RESP**
  - Both enables are 0.
  - `p<gnt>_ack` = 1 for this cycle only.
  - `last_gnt <= gnt`.
  - Go to IDLE unconditionally. No grant is made in RESP, so a requester still holding `req` during its ack cycle is never re-granted.
- Enables are 0 in IDLE and RESP. They are never both 1.
- `pN_rdata` holds its value until the next read completion on that port. Writes leave it unchanged.
- Addresses pass through unmodified; address translation belongs to the SRAM controller.

## Timing
- Reset (`rst` = 0, asynchronous) gives:
  - state IDLE, `last_gnt` = 1 (port 0 wins the first tie), `gnt` = 0
  - enables, acks and `busy` all 0
  - `mem_address`, `mem_write_data` and `pN_rdata` all 0
- `pN_ready` is combinational. It is 1 during reset unless `pN_req` = 1.
- Reset mid-BUSY aborts the transaction: enables drop asynchronously and no ack is issued.
- Timeline:
  - `req` seen in IDLE at cycle 0.
  - Enables are high from cycle 1.
  - If `mem_ready` = 1 at cycle k ≥ 1, ack occurs at cycle k+1 and IDLE resumes at k+2.
  - Minimum request-to-ack latency is 2 cycles.
- Back-to-back: a request pending at k+2 is granted that cycle, so the next enables rise at k+3. Enables are therefore low for at least 2 cycles between transactions. This keeps the SRAM controller idle for a cycle so a held enable never starts a duplicate transaction.
- Simultaneous requests in IDLE: the loser stays stalled (`ready` = 0) and wins the next IDLE cycle in which it is still requesting.
- A request dropped before grant is legal and is simply not served.
- `mem_ready` is ignored in IDLE and RESP.

## Test plan
- **Reset:** `rst` = 0 mid-BUSY -> enables 0 in the same cycle, state IDLE, no ack, `pN_rdata` = 0.
- **Single read:** `p0_req` = 1, `p0_we` = 0, `p0_addr` = 0x400; model asserts `mem_ready` 3 cycles after the enable with `mem_read_data` = 0xDEADBEEF -> `mem_read_en` high for cycles 1–3, `mem_address` = 0x400, `p0_ack` at cycle 4, `p0_rdata` = 0xDEADBEEF, `p0_ready` 0 during cycles 0–3.
- **Single write:** `p1_req`, `p1_we` = 1, `p1_addr` = 0x404, `p1_wdata` = 0x12345678 -> `mem_write_en` only, `mem_write_data` = 0x12345678, `p1_ack` once, `p1_rdata` unchanged.
- **Round-robin:** both ports request continuously -> grant order 0, 1, 0, 1; each ack exactly one cycle; enables low for at least 2 cycles between grants; enables never both high.
- **Fixed priority:** with `FIXED_PRIO` = 1 and both ports requesting -> port 0 wins every time; port 1 is served only once `p0_req` drops.
- **Input stability:** change `p0_addr` from 0x400 to 0x800 during BUSY -> `mem_address` stays 0x400 until the ack.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bundle of requester ports, SRAM-controller ports and status for sram_arbiter.
// slave = arbiter side, master = requesters plus controller model side.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p1_req;
  logic              p0_we;
  logic              p1_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p0_ack;
  logic              p1_ack;
  logic              p0_ready;
  logic              p1_ready;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_ready;
  logic              gnt;
  logic              busy;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  mem_read_data, mem_ready,
    output p0_rdata, p1_rdata, p0_ack, p1_ack, p0_ready, p1_ready,
    output mem_read_en, mem_write_en, mem_address, mem_write_data, gnt, busy
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output mem_read_data, mem_ready,
    input  p0_rdata, p1_rdata, p0_ack, p1_ack, p0_ready, p1_ready,
    input  mem_read_en, mem_write_en, mem_address, mem_write_data, gnt, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller: one latched transaction
// at a time, one-cycle ack, round-robin or fixed-priority grant.
module sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  sram_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_reg;
  logic              last_gnt_reg;
  logic              gnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              read_en_reg;
  logic              write_en_reg;
  logic              busy_reg;
  logic [1:0]        ack_reg;
  logic [DATA_W-1:0] rdata_reg [2];

  logic [1:0]        req_vec;
  logic [1:0]        ready_vec;
  logic              tie_pick;
  logic              win_port;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req_vec = {bus.p1_req, bus.p0_req};

  generate
    if (FIXED_PRIO) begin : g_fixed
      assign tie_pick = 1'b0;
    end else begin : g_rr
      assign tie_pick = ~last_gnt_reg;
    end
  endgenerate

  always_comb begin
    win_port = tie_pick;
    if (req_vec == 2'b01)
      win_port = 1'b0;
    else if (req_vec == 2'b10)
      win_port = 1'b1;
  end

  assign win_we    = win_port ? bus.p1_we    : bus.p0_we;
  assign win_addr  = win_port ? bus.p1_addr  : bus.p0_addr;
  assign win_wdata = win_port ? bus.p1_wdata : bus.p0_wdata;

  // A port stalls from the moment it requests until its ack cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_vec[gi] = ~(req_vec[gi] & ~ack_reg[gi]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      gnt_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      read_en_reg  <= 1'b0;
      write_en_reg <= 1'b0;
      busy_reg     <= 1'b0;
      ack_reg      <= 2'b00;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ack_reg <= 2'b00;
          if (|req_vec) begin
            gnt_reg      <= win_port;
            we_reg       <= win_we;
            addr_reg     <= win_addr;
            wdata_reg    <= win_wdata;
            read_en_reg  <= ~win_we;
            write_en_reg <= win_we;
            busy_reg     <= 1'b1;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            if (!we_reg)
              rdata_reg[gnt_reg] <= bus.mem_read_data;
            read_en_reg      <= 1'b0;
            write_en_reg     <= 1'b0;
            ack_reg[gnt_reg] <= 1'b1;
            state_reg        <= RESP;
          end
        end
        RESP: begin
          // No grant here so a requester still holding req during its ack is not re-served.
          ack_reg      <= 2'b00;
          last_gnt_reg <= gnt_reg;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.p0_rdata       = rdata_reg[0];
  assign bus.p1_rdata       = rdata_reg[1];
  assign bus.p0_ack         = ack_reg[0];
  assign bus.p1_ack         = ack_reg[1];
  assign bus.p0_ready       = ready_vec[0];
  assign bus.p1_ready       = ready_vec[1];
  assign bus.mem_read_en    = read_en_reg;
  assign bus.mem_write_en   = write_en_reg;
  assign bus.mem_address    = addr_reg;
  assign bus.mem_write_data = wdata_reg;
  assign bus.gnt            = gnt_reg;
  assign bus.busy           = busy_reg;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a round-robin instance and a fixed-priority
// instance, each fronting a 3-cycle SRAM controller model.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst_rr = 1'b0;
  logic rst_fp = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_rr ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_fp ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst_rr), .bus(if_rr.slave));
  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst_fp), .bus(if_fp.slave));

  // Controller model: ready in the third cycle an enable is seen high.
  int unsigned cnt_rr = 0;
  int unsigned cnt_fp = 0;
  logic [31:0] rd_val_rr = 32'h0;
  logic [31:0] rd_val_fp = 32'h0;
  always @(posedge clk) begin
    cnt_rr <= (if_rr.mem_read_en | if_rr.mem_write_en) ? cnt_rr + 1 : 0;
    cnt_fp <= (if_fp.mem_read_en | if_fp.mem_write_en) ? cnt_fp + 1 : 0;
  end
  assign if_rr.mem_ready     = (if_rr.mem_read_en | if_rr.mem_write_en) && (cnt_rr == 2);
  assign if_fp.mem_ready     = (if_fp.mem_read_en | if_fp.mem_write_en) && (cnt_fp == 2);
  assign if_rr.mem_read_data = rd_val_rr;
  assign if_fp.mem_read_data = rd_val_fp;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Protocol monitors on the round-robin instance.
  int both_hi = 0;
  int gap_viol = 0;
  int ack_wide = 0;
  int low_run = 0;
  bit seen_txn = 1'b0;
  bit prev_en = 1'b0;
  bit prev_ack0 = 1'b0;
  bit prev_ack1 = 1'b0;
  always @(negedge clk) begin
    if (if_rr.mem_read_en && if_rr.mem_write_en) both_hi++;
    if ((if_rr.mem_read_en | if_rr.mem_write_en) && !prev_en && seen_txn && low_run < 2) gap_viol++;
    if ((if_rr.mem_ready === 1'b0) && 1'b0) gap_viol++;
    if (if_rr.p0_ack && prev_ack0) ack_wide++;
    if (if_rr.p1_ack && prev_ack1) ack_wide++;
    if (if_rr.mem_read_en | if_rr.mem_write_en) begin
      seen_txn = 1'b1;
      low_run  = 0;
    end else begin
      low_run++;
    end
    prev_en   = if_rr.mem_read_en | if_rr.mem_write_en;
    prev_ack0 = if_rr.p0_ack;
    prev_ack1 = if_rr.p1_ack;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  logic [1:0] order [4];
  int n;
  int p0_cnt;
  int acks_seen;
  logic [1:0] exp_rr [4];
  logic [1:0] exp_fp [4];

  initial begin
    exp_rr = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_fp = '{2'd0, 2'd0, 2'd0, 2'd1};
    if_rr.p0_req = 0; if_rr.p1_req = 0; if_rr.p0_we = 0; if_rr.p1_we = 0;
    if_rr.p0_addr = 0; if_rr.p1_addr = 0; if_rr.p0_wdata = 0; if_rr.p1_wdata = 0;
    if_fp.p0_req = 0; if_fp.p1_req = 0; if_fp.p0_we = 0; if_fp.p1_we = 0;
    if_fp.p0_addr = 0; if_fp.p1_addr = 0; if_fp.p0_wdata = 0; if_fp.p1_wdata = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_read_en", if_rr.mem_read_en, 0);
    check_eq("rst_write_en", if_rr.mem_write_en, 0);
    check_eq("rst_busy", if_rr.busy, 0);
    check_eq("rst_gnt", if_rr.gnt, 0);
    check_eq("rst_ack", {if_rr.p1_ack, if_rr.p0_ack}, 0);
    check_eq("rst_addr", if_rr.mem_address, 0);
    check_eq("rst_p0_ready", if_rr.p0_ready, 1);
    if_rr.p0_req = 1; #1;
    check_eq("rst_p0_ready_req", if_rr.p0_ready, 0);
    if_rr.p0_req = 0;
    @(negedge clk); rst_rr = 1; rst_fp = 1;
    @(negedge clk);

    // Single read on port 0, with address change mid-transaction
    rd_val_rr = 32'hDEADBEEF;
    if_rr.p0_we = 0; if_rr.p0_addr = 32'h400; if_rr.p0_req = 1; #1;
    check_eq("rd_c0_ready", if_rr.p0_ready, 0);
    check_eq("rd_c0_en", if_rr.mem_read_en, 0);
    @(negedge clk);
    check_eq("rd_c1_en", {if_rr.mem_write_en, if_rr.mem_read_en}, 2'b01);
    check_eq("rd_c1_addr", if_rr.mem_address, 32'h400);
    check_eq("rd_c1_busy", if_rr.busy, 1);
    check_eq("rd_c1_gnt", if_rr.gnt, 0);
    if_rr.p0_addr = 32'h800;
    @(negedge clk);
    check_eq("rd_c2_en", if_rr.mem_read_en, 1);
    check_eq("rd_c2_ready", if_rr.p0_ready, 0);
    @(negedge clk);
    check_eq("rd_c3_en", if_rr.mem_read_en, 1);
    check_eq("rd_c3_addr_stable", if_rr.mem_address, 32'h400);
    check_eq("rd_c3_ack", if_rr.p0_ack, 0);
    @(negedge clk);
    check_eq("rd_c4_ack", {if_rr.p1_ack, if_rr.p0_ack}, 2'b01);
    check_eq("rd_c4_en", if_rr.mem_read_en, 0);
    check_eq("rd_c4_rdata", if_rr.p0_rdata, 32'hDEADBEEF);
    check_eq("rd_c4_ready", if_rr.p0_ready, 1);
    if_rr.p0_req = 0;
    @(negedge clk);
    check_eq("rd_c5_ack", if_rr.p0_ack, 0);
    check_eq("rd_c5_busy", if_rr.busy, 0);

    // Single write on port 1
    @(negedge clk);
    if_rr.p1_we = 1; if_rr.p1_addr = 32'h404; if_rr.p1_wdata = 32'h12345678; if_rr.p1_req = 1;
    @(negedge clk);
    check_eq("wr_c1_en", {if_rr.mem_write_en, if_rr.mem_read_en}, 2'b10);
    check_eq("wr_c1_wdata", if_rr.mem_write_data, 32'h12345678);
    check_eq("wr_c1_addr", if_rr.mem_address, 32'h404);
    check_eq("wr_c1_gnt", if_rr.gnt, 1);
    repeat (3) @(negedge clk);
    check_eq("wr_c4_ack", {if_rr.p1_ack, if_rr.p0_ack}, 2'b10);
    check_eq("wr_c4_p1_rdata", if_rr.p1_rdata, 0);
    check_eq("wr_c4_p0_rdata", if_rr.p0_rdata, 32'hDEADBEEF);
    if_rr.p1_req = 0;
    @(negedge clk);
    check_eq("wr_c5_ack", if_rr.p1_ack, 0);

    // Round-robin with both ports requesting continuously
    rd_val_rr = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) order[i] = 2'd3;
    n = 0;
    if_rr.p0_we = 0; if_rr.p0_addr = 32'h100;
    if_rr.p1_we = 1; if_rr.p1_addr = 32'h200; if_rr.p1_wdata = 32'hCAFE0001;
    if_rr.p0_req = 1; if_rr.p1_req = 1;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (if_rr.p0_ack && n < 4) begin order[n] = 2'd0; n++; end
      if (if_rr.p1_ack && n < 4) begin order[n] = 2'd1; n++; end
    end
    if_rr.p0_req = 0; if_rr.p1_req = 0;
    check_eq("rr_ack_count", n, 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("rr_order%0d", i), order[i], exp_rr[i]);
    check_eq("rr_p0_rdata", if_rr.p0_rdata, 32'h0BADF00D);
    check_eq("rr_p1_rdata", if_rr.p1_rdata, 0);
    repeat (3) @(negedge clk);
    check_eq("mon_both_en", both_hi, 0);
    check_eq("mon_gap", gap_viol, 0);
    check_eq("mon_ack_width", ack_wide, 0);

    // Fixed priority: port 0 wins until it drops its request
    rd_val_fp = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) order[i] = 2'd3;
    n = 0; p0_cnt = 0;
    if_fp.p0_addr = 32'h10; if_fp.p1_addr = 32'h20;
    if_fp.p0_req = 1; if_fp.p1_req = 1;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (if_fp.p0_ack && n < 4) begin
        order[n] = 2'd0; n++; p0_cnt++;
        if (p0_cnt == 3) if_fp.p0_req = 0;
      end
      if (if_fp.p1_ack && n < 4) begin order[n] = 2'd1; n++; end
    end
    if_fp.p0_req = 0; if_fp.p1_req = 0;
    check_eq("fp_ack_count", n, 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("fp_order%0d", i), order[i], exp_fp[i]);
    check_eq("fp_p1_rdata", if_fp.p1_rdata, 32'h55AA55AA);

    // Reset in the middle of BUSY aborts the transaction
    @(negedge clk);
    rd_val_rr = 32'h11111111;
    if_rr.p0_we = 0; if_rr.p0_addr = 32'h400; if_rr.p0_req = 1;
    repeat (2) @(negedge clk);
    check_eq("ab_pre_en", if_rr.mem_read_en, 1);
    rst_rr = 0; #1;
    check_eq("ab_en", {if_rr.mem_write_en, if_rr.mem_read_en}, 0);
    check_eq("ab_busy", if_rr.busy, 0);
    check_eq("ab_rdata", if_rr.p0_rdata, 0);
    check_eq("ab_addr", if_rr.mem_address, 0);
    if_rr.p0_req = 0;
    @(negedge clk); rst_rr = 1;
    acks_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_rr.p0_ack | if_rr.p1_ack | if_rr.mem_read_en) acks_seen++;
    end
    check_eq("ab_no_ack", acks_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
